fpu_shift_arb: RTL
==================

# fpu_shift_arb

Shared 16-bit logical right-shift unit for the FPU execute stage, multiplexed among up to NREQ requesters (exponent alignment, normalization, float-to-int conversion). Grants one requester per cycle round-robin over a valid/ready handshake and shifts the granted operand through an internal 4-stage barrel shifter (stages of 1, 2, 4 and 8). Also computes a sticky bit for rounding. Returns the result, tagged with the requester index, through a single registered output slot with backpressure.

## Interface
- NREQ, 3, number of requesters (2..4)
- IDW, $clog2(NREQ), width of requester tag
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  NREQ  bit i: requester i presents an operand
- req_ready  out  NREQ  bit i: requester i's operand is taken this cycle; at most one bit high
- req_data  in  16*NREQ  operand of requester i at [16i+15:16i]
- req_shamt  in  5*NREQ  shift amount of requester i at [5i+4:5i], range 0..31
- resp_valid  out  1  result slot holds a valid result
- resp_ready  in  1  consumer accepts result this cycle
- resp_id  out  IDW  index of the requester that produced the result
- resp_data  out  16  shifted operand
- resp_sticky  out  1  OR of all bits shifted out
- busy  out  1  resp_valid OR any req_valid

## Operation
- Slot state: EMPTY (resp_valid=0) or FULL (resp_valid=1).
- can_accept = !rst & (!resp_valid | resp_ready).
- Arbitration:
  - Round-robin pointer ptr (IDW bits, 0..NREQ-1). Search starts at ptr and runs upward modulo NREQ.
  - The first i with req_valid[i]=1 gets the grant.
  - req_ready[i] = grant[i] & can_accept.
  - req_ready may depend combinationally on req_valid.
- Transfer: req_valid[i] & req_ready[i]. On transfer:
  - ptr <= (i+1) mod NREQ
  - resp_id <= i
  - resp_data <= shifted operand
  - resp_sticky <= sticky bit
  - resp_valid <= 1
- No transfer: ptr unchanged. If resp_valid & resp_ready, then resp_valid <= 0. resp_data, resp_id and resp_sticky hold their values.
- Simultaneous drain and accept: the slot reloads with the new result and resp_valid stays 1. This gives full throughput of 1 result per cycle.
- Stall (resp_valid & !resp_ready): req_ready = 0. resp_data, resp_id and resp_sticky are held stable.
- Shift arithmetic (d = req_data slice, s = req_shamt slice):
  - s = 0: result d, sticky 0.
  - 1 ≤ s ≤ 15: result d >> s with zero fill; sticky = |d[s-1:0].
  - s ≥ 16: result 0; sticky = |d.
  - Shift-amount bit 4 forces a zero result after the 4-stage shifter, which uses bits 3:0.
- Requester obligation, checked in the bench: once req_valid[i] is raised, it and its data and shamt stay stable until transfer. The block does not depend on this for correctness.
- busy is combinational.

## Timing
- Reset (rst high at a clock edge):
  - resp_valid=0, resp_data=16'h0000, resp_sticky=0, resp_id=0, ptr=0.
  - req_ready=0 while rst is high.
  - A pending result is discarded. No operand is accepted in a reset cycle.
- Latency: operand transferred at edge N → resp_valid=1 with its result visible after edge N, i.e. during cycle N+1. One cycle latency.
- Throughput: 1 operand per cycle while resp_ready=1.
- Fairness: with all NREQ requesters continuously valid and resp_ready=1, grants rotate 0,1,...,NREQ-1,0,... Each requester waits at most NREQ-1 transfers.
- Paths:
  - req_ready is combinational from req_valid, resp_valid, resp_ready, ptr and rst.
  - resp_* are registered.
  - No combinational path from req_data to any output.

## Test plan
- Reset then single request: rst for 2 cycles; req_valid=3'b001, data 16'hB5A3, shamt 4, resp_ready=1 → req_ready[0]=1 in the first cycle after reset. Next cycle: resp_valid=1, resp_data=16'h0B5A, resp_sticky=1 (low bits 4'h3), resp_id=0.
- Shift edge cases on requester 1:
  - shamt 0, data 16'h8001 → 16'h8001, sticky 0
  - shamt 15, data 16'h8001 → 16'h0001, sticky 1
  - shamt 16, data 16'h8000 → 16'h0000, sticky 1
  - shamt 31, data 16'h0000 → 16'h0000, sticky 0
- Round-robin: all three requesters valid for 6 cycles with resp_ready=1 → resp_id sequence 0,1,2,0,1,2. Exactly one req_ready bit is high per cycle.
- Backpressure: slot FULL, resp_ready=0 for 3 cycles with req_valid=3'b110 → req_ready=0 and resp_* unchanged throughout. When resp_ready rises, the held result drains and requester 1 is accepted in the same cycle. The next cycle shows requester 1's result, with no bubble.
- Pointer skip: ptr=1 and only requester 0 valid → grant to 0, after which ptr=1.
- Reset mid-operation: slot FULL with resp_ready=0, rst asserted for 1 cycle → resp_valid=0 and resp_data=0 afterwards, the held result is never presented, and ptr=0 (requester 0 wins the next 3-way contention).

Source files
------------

// File: rtl/fpu_shift_arb.sv
`timescale 1ns/1ps
// Shared 16-bit logical right shifter for the FPU execute stage: round-robin
// arbitration among NREQ requesters, sticky-bit generation, one registered result slot.
module fpu_shift_arb #(
  parameter int NREQ = 3,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_data,
  input  logic [5*NREQ-1:0]    req_shamt,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [15:0]          resp_data,
  output logic                 resp_sticky,
  output logic                 busy
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           resp_valid_q, resp_valid_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic [15:0]    resp_data_q, resp_data_d;
  logic           resp_sticky_q, resp_sticky_d;

  logic            can_accept;
  logic            found;
  logic            xfer;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW:0]    cand;
  logic [15:0]     op_data;
  logic [4:0]      op_shamt;
  logic [15:0]     sh_v;
  logic            sh_sticky;

  assign can_accept = !rst && (!resp_valid_q || resp_ready);

  // Scan upward from ptr, wrapping at NREQ; first valid requester wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found                  = 1'b1;
        gnt_idx                = cand[IDW-1:0];
        grant[cand[IDW-1:0]]   = 1'b1;
      end
    end
  end

  assign req_ready = can_accept ? grant : '0;
  assign xfer      = can_accept && found;

  always_comb begin
    op_data  = '0;
    op_shamt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        op_data  = req_data[16*i +: 16];
        op_shamt = req_shamt[5*i +: 5];
      end
    end
  end

  // Barrel stages 1/2/4/8 collect the bits they drop; bit 4 flushes whatever remains.
  always_comb begin
    sh_v      = op_data;
    sh_sticky = 1'b0;
    if (op_shamt[0]) begin
      sh_sticky = sh_sticky | sh_v[0];
      sh_v      = {1'b0, sh_v[15:1]};
    end
    if (op_shamt[1]) begin
      sh_sticky = sh_sticky | (|sh_v[1:0]);
      sh_v      = {2'b0, sh_v[15:2]};
    end
    if (op_shamt[2]) begin
      sh_sticky = sh_sticky | (|sh_v[3:0]);
      sh_v      = {4'b0, sh_v[15:4]};
    end
    if (op_shamt[3]) begin
      sh_sticky = sh_sticky | (|sh_v[7:0]);
      sh_v      = {8'b0, sh_v[15:8]};
    end
    if (op_shamt[4]) begin
      sh_sticky = sh_sticky | (|sh_v);
      sh_v      = '0;
    end
  end

  always_comb begin
    ptr_d         = ptr_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_data_d   = resp_data_q;
    resp_sticky_d = resp_sticky_q;
    if (xfer) begin
      ptr_d         = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
      resp_valid_d  = 1'b1;
      resp_id_d     = gnt_idx;
      resp_data_d   = sh_v;
      resp_sticky_d = sh_sticky;
    end else if (resp_valid_q && resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_data_q   <= '0;
      resp_sticky_q <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_data_q   <= resp_data_d;
      resp_sticky_q <= resp_sticky_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_data   = resp_data_q;
  assign resp_sticky = resp_sticky_q;
  assign busy        = resp_valid_q || (|req_valid);

endmodule
